// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALUdec/ALU pair between two requesters.
// Operands are registered into the ALU, and the result is held until the granted requester accepts it.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_opcode,
    input  logic [5:0]       req0_funct,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_opcode,
    input  logic [5:0]       req1_funct,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    output logic [5:0]       alu_opcode,
    output logic [5:0]       alu_funct,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             win0;
    logic             win1;
    logic             accept;
    logic             win_id;
    logic             rsp_ack;

    logic [5:0]       opcode_p1;
    logic [5:0]       funct_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic             gid_p1;
    logic [WIDTH-1:0] result_p2;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        win0 = req0_valid && (!req1_valid || last_grant);
        win1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_ack    = gid_p1 ? rsp1_ready : rsp0_ready;
        case (state)
            IDLE: begin
                req0_ready = win0;
                req1_ready = win1;
                if (win0 || win1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = !gid_p1;
                rsp1_valid = gid_p1;
                if (rsp_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = req0_ready || req1_ready;
    assign win_id = req1_ready;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= win_id;
            end
        end
    end

    // p1: winner's request registered onto the shared ALU inputs
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            opcode_p1 <= '0;
            funct_p1  <= '0;
            a_p1      <= '0;
            b_p1      <= '0;
            gid_p1    <= 1'b0;
        end else if (accept) begin
            opcode_p1 <= win_id ? req1_opcode : req0_opcode;
            funct_p1  <= win_id ? req1_funct  : req0_funct;
            a_p1      <= win_id ? req1_A      : req0_A;
            b_p1      <= win_id ? req1_B      : req0_B;
            gid_p1    <= win_id;
        end
    end

    // p2: ALU result captured at the end of the single ISSUE cycle
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            result_p2 <= '0;
        end else if (state == ISSUE) begin
            result_p2 <= alu_out;
        end
    end

    assign alu_opcode = opcode_p1;
    assign alu_funct  = funct_p1;
    assign alu_A      = a_p1;
    assign alu_B      = b_p1;
    assign grant_id   = gid_p1;
    assign rsp_data   = result_p2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level arbitration model and a behavioural ALU.
module tb_alu_arbiter;
    localparam int WIDTH = 32;

    logic             Clock = 1'b0;
    logic             Reset_n;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [5:0]       req0_opcode, req0_funct, req1_opcode, req1_funct;
    logic [WIDTH-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [5:0]       alu_opcode, alu_funct;
    logic [WIDTH-1:0] alu_A, alu_B, alu_out, rsp_data;
    logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, grant_id;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_funct(req0_funct), .req0_A(req0_A), .req0_B(req0_B),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_funct(req1_funct), .req1_A(req1_A), .req1_B(req1_B),
        .alu_opcode(alu_opcode), .alu_funct(alu_funct), .alu_A(alu_A), .alu_B(alu_B),
        .alu_out(alu_out),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .grant_id(grant_id)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
        if (op == 6'b000000) begin
            case (fn)
                6'b100001: return a + b;
                6'b100011: return a - b;
                6'b100100: return a & b;
                6'b100101: return a | b;
                6'b100110: return a ^ b;
                6'b100111: return ~(a | b);
                6'b101010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'b101011: return (a < b) ? 32'd1 : 32'd0;
                default:   return 32'd0;
            endcase
        end
        case (op)
            6'b001001: return a + b;
            6'b001100: return a & b;
            6'b001101: return a | b;
            default:   return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared ALUdec/ALU pair
    always_comb alu_out = alu_f(alu_opcode, alu_funct, alu_A, alu_B);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;
    exp_t sbq[$];

    // Transaction-level model: 0 = free, 1 = operands on ALU, 2 = result offered
    int          ph    = 0;
    int          mlast = 1;
    int          mgid  = 0;
    int          pw;
    logic [5:0]  m_op, m_fn;
    logic [31:0] m_a, m_b;

    initial forever begin
        @(negedge Clock);
        if (!Reset_n) begin
            ph    = 0;
            mlast = 1;
            sbq.delete();
        end else begin
            case (ph)
                0: begin
                    pw = -1;
                    if (req0_valid && req1_valid) pw = (mlast == 0) ? 1 : 0;
                    else if (req0_valid)          pw = 0;
                    else if (req1_valid)          pw = 1;
                    chk("req0_ready", req0_ready, pw == 0);
                    chk("req1_ready", req1_ready, pw == 1);
                    chk("rsp_valid_idle", {rsp0_valid, rsp1_valid}, 0);
                    if (pw >= 0) begin
                        if (pw == 0) begin
                            m_op = req0_opcode; m_fn = req0_funct; m_a = req0_A; m_b = req0_B;
                        end else begin
                            m_op = req1_opcode; m_fn = req1_funct; m_a = req1_A; m_b = req1_B;
                        end
                        sbq.push_back('{id: pw, data: alu_f(m_op, m_fn, m_a, m_b)});
                        mlast = pw;
                        mgid  = pw;
                        ph    = 1;
                    end
                end
                1: begin
                    chk("ready_issue", {req0_ready, req1_ready}, 0);
                    chk("rsp_valid_issue", {rsp0_valid, rsp1_valid}, 0);
                    chk("grant_id_issue", grant_id, mgid);
                    chk("alu_opfn", {alu_opcode, alu_funct}, {m_op, m_fn});
                    chk("alu_A", alu_A, m_a);
                    chk("alu_B", alu_B, m_b);
                    ph = 2;
                end
                default: begin
                    chk("ready_resp", {req0_ready, req1_ready}, 0);
                    chk("rsp0_valid", rsp0_valid, mgid == 0);
                    chk("rsp1_valid", rsp1_valid, mgid == 1);
                    chk("grant_id_resp", grant_id, mgid);
                    if ((mgid == 0) ? rsp0_ready : rsp1_ready) ph = 0;
                end
            endcase
        end
    end

    // Response monitor: compares every presented response with the scoreboard head
    initial forever begin
        @(negedge Clock);
        if (Reset_n && (rsp0_valid || rsp1_valid)) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got port %0d data 0x%0h, expected none at %0t",
                         rsp1_valid ? 1 : 0, rsp_data, $time);
            end else begin
                chk("rsp_port", rsp1_valid ? 1 : 0, sbq[0].id);
                chk("rsp_data", rsp_data, sbq[0].data);
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
                    void'(sbq.pop_front());
            end
        end
    end

    task automatic set_req(input int id, input logic [11:0] opfn,
                           input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_opcode = opfn[11:6]; req0_funct = opfn[5:0];
            req0_A = a; req0_B = b; req0_valid = 1'b1;
        end else begin
            req1_opcode = opfn[11:6]; req1_funct = opfn[5:0];
            req1_A = a; req1_B = b; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_acc(input int id);
        int t   = 0;
        bit got = 1'b0;
        while (!got && t < 200) begin
            @(negedge Clock);
            got = (id == 0) ? req0_ready : req1_ready;
            t++;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req%0d ready 0 after %0d cycles, expected 1", id, t);
        end
        @(posedge Clock);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_alu_opfn", {alu_opcode, alu_funct}, 0);
        chk("rst_alu_A", alu_A, 0);
        chk("rst_alu_B", alu_B, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_flags", {grant_id, rsp0_valid, rsp1_valid}, 0);
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #1 Reset_n = 1'b0;
        #1 chk_reset_outputs();
        @(posedge Clock);
        @(posedge Clock);
        #3 Reset_n = 1'b1;
    endtask

    function automatic logic [11:0] rnd_opfn();
        case ($urandom_range(0, 10))
            0:       return {6'b000000, 6'b100001};
            1:       return {6'b000000, 6'b100011};
            2:       return {6'b000000, 6'b100100};
            3:       return {6'b000000, 6'b100101};
            4:       return {6'b000000, 6'b100110};
            5:       return {6'b000000, 6'b100111};
            6:       return {6'b000000, 6'b101010};
            7:       return {6'b000000, 6'b101011};
            8:       return {6'b001001, 6'b000000};
            9:       return {6'b001100, 6'b000000};
            default: return {6'b001101, 6'b000000};
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic requester(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge Clock);
                #1;
            end
            set_req(id, rnd_opfn(), rnd_val(), rnd_val());
            wait_acc(id);
        end
    endtask

    bit done = 1'b0;

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_opcode = 0; req0_funct = 0; req0_A = 0; req0_B = 0;
        req1_opcode = 0; req1_funct = 0; req1_A = 0; req1_B = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        #2 Reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #1 chk_reset_outputs();
        #2 Reset_n = 1'b1;

        // single ADDU request on port 0
        rsp0_ready = 1; rsp1_ready = 0;
        set_req(0, {6'b000000, 6'b100001}, 32'd5, 32'd7);
        wait_acc(0);
        repeat (4) begin @(posedge Clock); #1; end
        chk("single_data", rsp_data, 32'h0000_000C);

        // simultaneous requests straight after reset: port 0 first
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        set_req(0, {6'b000000, 6'b100011}, 32'd10, 32'd3);
        set_req(1, {6'b000000, 6'b100101}, 32'h0000_00F0, 32'h0000_000F);
        fork
            wait_acc(0);
            wait_acc(1);
        join
        repeat (3) begin @(posedge Clock); #1; end
        chk("simul_grant_id", grant_id, 1);
        chk("simul_data", rsp_data, 32'h0000_00FF);

        // response backpressure on port 1 with port 0 waiting
        rsp1_ready = 0;
        set_req(1, {6'b000000, 6'b100001}, 32'hFFFF_FFFF, 32'd1);
        wait_acc(1);
        set_req(0, {6'b000000, 6'b100100}, 32'h1234_5678, 32'h0F0F_0F0F);
        repeat (6) begin @(posedge Clock); #1; end
        chk("bp_rsp1_valid", rsp1_valid, 1);
        chk("bp_rsp_data", rsp_data, 32'h0000_0000);
        chk("bp_req0_ready", req0_ready, 0);
        rsp1_ready = 1;
        wait_acc(0);
        repeat (4) begin @(posedge Clock); #1; end

        // fairness with both requesters continuously valid
        do_reset();
        rsp0_ready = 1; rsp1_ready = 1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    set_req(0, rnd_opfn(), rnd_val(), rnd_val());
                    wait_acc(0);
                end
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    set_req(1, rnd_opfn(), rnd_val(), rnd_val());
                    wait_acc(1);
                end
            end
        join
        repeat (4) begin @(posedge Clock); #1; end

        // ready on the non-granted response port is ignored
        rsp0_ready = 0; rsp1_ready = 0;
        set_req(0, {6'b000000, 6'b100110}, 32'hAAAA_5555, 32'hFFFF_0000);
        wait_acc(0);
        @(posedge Clock); #1;
        rsp1_ready = 1;
        @(posedge Clock); #1;
        rsp1_ready = 0;
        chk("ign_rsp0_valid", rsp0_valid, 1);
        rsp0_ready = 1;
        repeat (3) begin @(posedge Clock); #1; end

        // reset during ISSUE drops the transaction
        set_req(0, {6'b000000, 6'b100001}, 32'd100, 32'd200);
        wait_acc(0);
        #2 Reset_n = 1'b0;
        #1 chk_reset_outputs();
        repeat (2) @(posedge Clock);
        #3 Reset_n = 1'b1;
        chk("post_rst_queue", sbq.size(), 0);
        rsp0_ready = 1; rsp1_ready = 1;
        set_req(0, {6'b001001, 6'b000000}, 32'd1, 32'd2);
        set_req(1, {6'b001101, 6'b000000}, 32'd4, 32'd8);
        fork
            wait_acc(0);
            wait_acc(1);
        join
        repeat (4) begin @(posedge Clock); #1; end

        // randomized traffic with random response backpressure
        fork
            begin
                fork
                    requester(0, 40);
                    requester(1, 40);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge Clock); #1;
                    rsp0_ready = 1'($urandom_range(0, 1));
                    rsp1_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp0_ready = 1; rsp1_ready = 1;
        repeat (10) begin @(posedge Clock); #1; end
        chk("drain_queue", sbq.size(), 0);
        chk("drain_idle", ph, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares one ALUdec/ALU pair between two requesters, such as a pipeline execute stage and a multi-cycle helper unit. Each requester submits opcode, funct and operands over a valid/ready handshake. The block grants one request at a time, round-robin, and drives registered operands into the shared ALU. It captures the ALU result and returns it on the granted requester's response port, holding it until that requester accepts.

## Interface
- WIDTH, 32, datapath width of A, B and the result
- Clock  in  1  rising-edge clock; the only clock
- Reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_opcode / req1_opcode  in  6  MIPS opcode
- req0_funct / req1_funct  in  6  MIPS funct
- req0_A / req1_A  in  WIDTH  operand A
- req0_B / req1_B  in  WIDTH  operand B
- alu_opcode  out  6  registered, to ALUdec.opcode
- alu_funct  out  6  registered, to ALUdec.funct
- alu_A  out  WIDTH  registered, to ALU.A
- alu_B  out  WIDTH  registered, to ALU.B
- alu_out  in  WIDTH  from ALU.Out (combinational through ALUdec/ALU)
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester accepts result
- rsp_data  out  WIDTH  result register, shared by both response ports
- grant_id  out  1  requester owning the current transaction

## Operation
- Reset values (async, Reset_n low): state=IDLE; last_grant=1; all alu_* outputs, rsp_data and grant_id are 0; rspX_valid=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner selection: if exactly one reqX_valid is high, that requester wins. If both are high, the requester other than last_grant wins.
  - reqX_ready=1 only for the winner, only in IDLE. The ready of the losing or idle requester is 0.
  - On a clock edge with valid&ready, the block latches the winner's opcode, funct, A and B into alu_*. It then sets grant_id=last_grant=winner and moves to ISSUE.
- ISSUE: lasts exactly one cycle, with no ready asserted. At the end of the cycle the block captures alu_out into rsp_data and moves to RESP.
- RESP:
  - rsp[grant_id]_valid=1; the other rsp_valid is 0.
  - rsp_data stays stable until the edge on which rsp[grant_id]_ready=1, after which the state goes to IDLE.
  - rsp_ready of the non-granted port is ignored.
- alu_* hold their last values outside the latch edge. No bubbles or zeros are inserted.
- The block performs no arithmetic itself; ALUdec/ALU semantics define the result width (WIDTH).
- Requests must hold valid, opcode, funct and operands stable until accepted. A request is never lost while it is waiting.

## Timing
- Accept edge = cycle N. ALU inputs are valid during cycle N+1. rsp_valid goes high from cycle N+2.
- If rsp_ready is high in cycle N+2, the next accept can occur at cycle N+3. Peak throughput is 1 operation per 3 cycles.
- Response backpressure stalls both requesters, because no reqX_ready is asserted outside IDLE.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1,...
- After reset, req0 wins the first simultaneous request.
- Reset asserted mid-transaction (ISSUE or RESP): the transaction is dropped without a response, and all outputs return to reset values immediately (asynchronous). After Reset_n deasserts, the first accept is possible on the first rising edge.
- reqX_ready and rspX_valid are functions of registered state only. reqX_ready also depends on reqX_valid. There is no combinational path from rspX_ready to any output.

## Test plan
- Single request: req0 ADDU (opcode 000000, funct 100001), A=5, B=7, rsp0_ready=1. Required: req0_ready high in the accept cycle N; rsp0_valid and rsp_data=0x0000000C in cycle N+2; IDLE again in N+3; rsp1_valid stays 0 throughout.
- Simultaneous, after reset: req0 SUBU (funct 100011) A=10 B=3, and req1 OR (funct 100101) A=0xF0 B=0x0F. Required: req0 granted first with rsp0 data 0x7; then req1 with rsp1 data 0xFF and grant_id=1.
- Backpressure: req1 ADDU A=0xFFFFFFFF B=1, rsp1_ready low for 5 cycles. Required: rsp1_valid held with rsp_data=0x00000000 stable; req0_ready and req1_ready stay 0; completion on the first rsp1_ready=1 edge.
- Fairness: both requesters valid for 6 transactions. Required: grant order 0,1,0,1,0,1, with one accept every 3 cycles.
- Reset mid-operation: assert Reset_n=0 during ISSUE of a req0 transaction. Required: no rsp0_valid, all outputs 0, last_grant=1. A subsequent simultaneous request grants req0.
- Non-granted ready ignored: in RESP for req0, pulse rsp1_ready. Required: no state change; rsp0_valid stays high.
